// File: rtl/m2_phase_gen.sv
// Purpose: synchronise and deglitch raw CPU M2, derive phase qualifiers, edge strobes, period and idle detect.
// Latency: raw M2 edge sampled at edge k reaches m2_f at edge k+1+GLITCH; strobes are coincident with m2_f.
// Backpressure: none; free-running observer with no handshake, every output updates each clk.
module m2_phase_gen #(
    parameter int GLITCH   = 2,
    parameter int CE_TAPS  = 2,
    parameter int WE_TAPS  = 8,
    parameter int M3_DLY   = 10,
    parameter int CW       = 8,
    parameter int PW       = 12,
    parameter int IDLE_CYC = 1000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m2,
    output logic          m2_f,
    output logic          m2_rise,
    output logic          m2_fall,
    output logic [CW-1:0] hi_cnt,
    output logic          ce_ok,
    output logic          we_ok,
    output logic          m3,
    output logic [PW-1:0] per_cnt,
    output logic          per_vld,
    output logic          m2_idle
);

    localparam logic [CW-1:0] HI_MAX = '1;
    localparam logic [PW-1:0] P_MAX  = '1;

    logic              s1;
    logic              s2;
    logic [GLITCH-1:0] flt;
    logic [GLITCH-1:0] flt_nxt;
    logic              rise_nxt;
    logic              fall_nxt;
    logic [CW-1:0]     hi_nxt;
    logic [PW-1:0]     run_ctr;
    logic [PW-1:0]     idle_ctr;
    logic [PW-1:0]     idle_nxt;
    logic              seen_rise;

    // The filter decision looks at the window including the sample being shifted in,
    // which is what makes the level change land at k+1+GLITCH rather than one later.
    if (GLITCH == 1) begin : g_flt1
        assign flt_nxt = s2;
    end else begin : g_fltn
        assign flt_nxt = {flt[GLITCH-2:0], s2};
    end

    assign rise_nxt = ~m2_f & (&flt_nxt);
    assign fall_nxt =  m2_f & ~(|flt_nxt);

    // Next high-phase count: load 1 on rise, count while high, saturate, zero otherwise.
    always_comb begin
        hi_nxt = '0;
        if (rise_nxt) begin
            hi_nxt = CW'(1);
        end else if (m2_f && !fall_nxt) begin
            hi_nxt = (hi_cnt == HI_MAX) ? hi_cnt : hi_cnt + CW'(1);
        end
    end

    // Next idle count: any filtered edge restarts it, otherwise it counts and saturates.
    always_comb begin
        idle_nxt = '0;
        if (!(rise_nxt || fall_nxt)) begin
            idle_nxt = (idle_ctr == P_MAX) ? idle_ctr : idle_ctr + PW'(1);
        end
    end

    // Synchroniser, filter, level and edge strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            flt     <= '0;
            m2_f    <= 1'b0;
            m2_rise <= 1'b0;
            m2_fall <= 1'b0;
        end else begin
            s1      <= m2;
            s2      <= s1;
            flt     <= flt_nxt;
            m2_rise <= rise_nxt;
            m2_fall <= fall_nxt;
            if (rise_nxt) begin
                m2_f <= 1'b1;
            end else if (fall_nxt) begin
                m2_f <= 1'b0;
            end
        end
    end

    // High counter and m3; m3 fires only on the step into M3_DLY so saturation cannot repeat it.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_cnt <= '0;
            m3     <= 1'b0;
        end else begin
            hi_cnt <= hi_nxt;
            m3     <= (hi_nxt == CW'(M3_DLY)) && (hi_nxt != hi_cnt);
        end
    end

    // Period measurement between filtered rises; first rise after reset only arms per_vld.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_ctr   <= '0;
            per_cnt   <= '0;
            per_vld   <= 1'b0;
            seen_rise <= 1'b0;
        end else if (rise_nxt) begin
            per_cnt   <= run_ctr;
            run_ctr   <= PW'(1);
            seen_rise <= 1'b1;
            per_vld   <= per_vld | seen_rise;
        end else begin
            run_ctr   <= (run_ctr == P_MAX) ? run_ctr : run_ctr + PW'(1);
        end
    end

    // Idle detect; compare on the next count so it clears on the same clock as the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_ctr <= '0;
            m2_idle  <= 1'b0;
        end else begin
            idle_ctr <= idle_nxt;
            m2_idle  <= (idle_nxt >= PW'(IDLE_CYC));
        end
    end

    assign ce_ok = m2_f & (hi_cnt >= CW'(CE_TAPS));
    assign we_ok = m2_f & (hi_cnt >= CW'(WE_TAPS));

endmodule

// File: tb/tb_m2_phase_gen.sv
// Purpose: randomized and directed stimulus for m2_phase_gen, scored against an event-timestamp model.
// Latency: expected vector for each clock is queued before the edge and popped 1ns after it.
// Backpressure: none; the monitor consumes one expected vector per clock.
module tb_m2_phase_gen;

    localparam int G    = 2;
    localparam int CET  = 2;
    localparam int WET  = 8;
    localparam int M3D  = 10;
    localparam int IDLE = 1000;
    localparam int HMAX = 255;
    localparam int PMAX = 4095;

    typedef struct packed {
        logic        f;
        logic        rise;
        logic        fall;
        logic [7:0]  hi;
        logic        ce;
        logic        we;
        logic        m3;
        logic [11:0] per;
        logic        pvld;
        logic        idle;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m2  = 1'b0;
    logic        m2_f;
    logic        m2_rise;
    logic        m2_fall;
    logic [7:0]  hi_cnt;
    logic        ce_ok;
    logic        we_ok;
    logic        m3;
    logic [11:0] per_cnt;
    logic        per_vld;
    logic        m2_idle;

    m2_phase_gen dut (
        .clk     (clk),
        .rst     (rst),
        .m2      (m2),
        .m2_f    (m2_f),
        .m2_rise (m2_rise),
        .m2_fall (m2_fall),
        .hi_cnt  (hi_cnt),
        .ce_ok   (ce_ok),
        .we_ok   (we_ok),
        .m3      (m3),
        .per_cnt (per_cnt),
        .per_vld (per_vld),
        .m2_idle (m2_idle)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model state: timestamps of events rather than counters.
    int cyc     = 0;
    int hist[$];
    bit lvl     = 0;
    int rise_c  = -1;
    int fall_c  = -1;
    int anchor  = 0;
    int edge_c  = 0;
    int nrise   = 0;
    int per_v   = 0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model(input bit r, input bit m);
        obs_t e;
        int   h;
        bit   all1;
        bit   all0;
        cyc++;
        e = '0;
        if (r) begin
            hist = {};
            repeat (G + 1) hist.push_back(0);
            lvl    = 0;
            rise_c = -1;
            fall_c = -1;
            anchor = cyc + 1;
            edge_c = cyc;
            nrise  = 0;
            per_v  = 0;
        end else begin
            all1 = 1;
            all0 = 1;
            for (int i = 0; i < G; i++) begin
                if (hist[i] != 0) all0 = 0;
                else              all1 = 0;
            end
            if (!lvl && all1) begin
                lvl    = 1;
                nrise++;
                per_v  = imin(cyc - anchor, PMAX);
                anchor = cyc;
                rise_c = cyc;
                edge_c = cyc;
            end else if (lvl && all0) begin
                lvl    = 0;
                fall_c = cyc;
                edge_c = cyc;
            end
            hist.push_back(int'(m));
            void'(hist.pop_front());
            h      = lvl ? imin(cyc - rise_c + 1, HMAX) : 0;
            e.f    = lvl;
            e.rise = (cyc == rise_c);
            e.fall = (cyc == fall_c);
            e.hi   = 8'(h);
            e.ce   = lvl && (h >= CET);
            e.we   = lvl && (h >= WET);
            e.m3   = lvl && ((cyc - rise_c + 1) == M3D);
            e.per  = 12'(per_v);
            e.pvld = (nrise >= 2);
            e.idle = (imin(cyc - edge_c, PMAX) >= IDLE);
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input bit r, input bit m);
        rst = r;
        m2  = m;
        model(r, m);
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit m);
        repeat (n) step(1'b0, m);
    endtask

    // Monitor: one expected vector per clock, compared just after the active edge.
    always @(posedge clk) begin
        obs_t e;
        obs_t got;
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {m2_f, m2_rise, m2_fall, hi_cnt, ce_ok, we_ok, m3, per_cnt, per_vld, m2_idle};
            n_vec++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL outputs t=%0t got f=%b r=%b fl=%b hi=%0d ce=%b we=%b m3=%b per=%0d pv=%b idle=%b want f=%b r=%b fl=%b hi=%0d ce=%b we=%b m3=%b per=%0d pv=%b idle=%b",
                         $time, got.f, got.rise, got.fall, got.hi, got.ce, got.we, got.m3, got.per, got.pvld, got.idle,
                         e.f, e.rise, e.fall, e.hi, e.ce, e.we, e.m3, e.per, e.pvld, e.idle);
            end
        end
    end

    initial begin
        bit lv;
        // Reset
        repeat (3) step(1'b1, 1'b0);
        // Free-running 28-clock period
        repeat (4) begin
            run(14, 1'b1);
            run(14, 1'b0);
        end
        // 1-clock high glitches on a low M2
        repeat (5) begin
            run(1, 1'b1);
            run(5, 1'b0);
        end
        // 1-clock dropouts during a high phase
        run(12, 1'b1);
        repeat (4) begin
            run(1, 1'b0);
            run(4, 1'b1);
        end
        run(14, 1'b0);
        // Long high phase: hi_cnt saturation, single m3
        run(400, 1'b1);
        run(20, 1'b0);
        run(14, 1'b1);
        run(14, 1'b0);
        // Long low: idle detect, then period saturation on the next rise
        run(4300, 1'b0);
        repeat (2) begin
            run(14, 1'b1);
            run(14, 1'b0);
        end
        // Reset mid high phase with M2 held high
        run(7, 1'b1);
        step(1'b1, 1'b1);
        run(30, 1'b1);
        repeat (2) begin
            run(14, 1'b0);
            run(14, 1'b1);
        end
        run(14, 1'b0);
        // Short high phase
        run(6, 1'b1);
        run(20, 1'b0);
        // Random run lengths with occasional reset
        lv = 1'b0;
        repeat (150) begin
            lv = ~lv;
            run(int'($urandom_range(1, 20)), lv);
            if ($urandom_range(0, 29) == 0) step(1'b1, lv);
        end
        run(5, 1'b0);
        @(posedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
